riscv_soft_mem_arbiter: RTL and testbench

- Parametrised N-channel memory arbiter for the soft tile; generalises the fixed i_cache/d_cache/htif wiring to any number of requesters.
- Requesters are caches and the HTIF bridge. They share one backing-memory port through round-robin arbitration.
- Supports up to MAX_OUT in-order outstanding requests. An internal tag FIFO routes each memory response back to the channel that issued it.

---
 rtl/riscv_soft_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_riscv_soft_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_soft_mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port among N_CH requesters.
// A tag FIFO returns each in-order memory response to its issuing channel.
module riscv_soft_mem_arbiter #(
   parameter int N_CH    = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int OPT_W   = 3,
   parameter int MAX_OUT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH-1:0]          req_valid,
   output logic [N_CH-1:0]          req_ready,
   input  logic [N_CH-1:0]          req_op,
   input  logic [N_CH*OPT_W-1:0]    req_op_type,
   input  logic [N_CH*ADDR_W-1:0]   req_addr,
   input  logic [N_CH*DATA_W-1:0]   req_data,
   output logic [N_CH-1:0]          resp_valid,
   output logic [DATA_W-1:0]        resp_data,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_req_op,
   output logic [OPT_W-1:0]         mem_req_op_type,
   output logic [ADDR_W-1:0]        mem_req_addr,
   output logic [DATA_W-1:0]        mem_req_data,
   input  logic                     mem_resp_valid,
   input  logic [DATA_W-1:0]        mem_resp_data,
   output logic                     err_orphan_resp
);

   localparam int TAG_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUT);
   localparam logic [TAG_W-1:0] LAST_CH   = TAG_W'(N_CH - 1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUT - 1);

   logic [TAG_W-1:0] rr_ptr;
   logic [TAG_W-1:0] gnt;
   logic             found;
   logic             space;
   logic             pop;
   logic             fire;
   logic [TAG_W-1:0] tags [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [TAG_W-1:0] head;
   logic [N_CH-1:0]  head_oh;

   // Scan from rr_ptr upward, wrapping, and take the first valid channel.
   always_comb begin
      gnt   = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % N_CH]) begin
            found = 1'b1;
            gnt   = TAG_W'((int'(rr_ptr) + k) % N_CH);
         end
      end
   end

   assign head          = tags[rd_ptr];
   assign pop           = mem_resp_valid && (count != '0);
   assign space         = (count < CNT_MAX) || pop;
   assign mem_req_valid = found && space;
   assign fire          = mem_req_valid && mem_req_ready;

   always_comb begin
      req_ready = '0;
      if (fire)
         req_ready[gnt] = 1'b1;
   end

   always_comb begin
      mem_req_op      = 1'b0;
      mem_req_op_type = '0;
      mem_req_addr    = '0;
      mem_req_data    = '0;
      if (found) begin
         mem_req_op      = req_op[gnt];
         mem_req_op_type = req_op_type[gnt*OPT_W +: OPT_W];
         mem_req_addr    = req_addr[gnt*ADDR_W +: ADDR_W];
         mem_req_data    = req_data[gnt*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      head_oh       = '0;
      head_oh[head] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (fire)
         tags[wr_ptr] <= gnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr          <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         resp_valid      <= '0;
         resp_data       <= '0;
         err_orphan_resp <= 1'b0;
      end else begin
         if (fire) begin
            rr_ptr <= (gnt == LAST_CH) ? '0 : gnt + 1'b1;
            wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
         case ({fire, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         resp_valid <= pop ? head_oh : '0;
         if (pop)
            resp_data <= mem_resp_data;
         // A push in the same cycle never satisfies a response.
         if (mem_resp_valid && (count == '0))
            err_orphan_resp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_riscv_soft_mem_arbiter.sv
// Directed plus randomized bench for riscv_soft_mem_arbiter.
// Expected values come from a queue-based model of outstanding tags.
module tb_riscv_soft_mem_arbiter;

   localparam int NC = 3;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    req_valid = '0;
   logic [2:0]    req_ready;
   logic [2:0]    req_op = '0;
   logic [8:0]    req_op_type = '0;
   logic [95:0]   req_addr = '0;
   logic [95:0]   req_data = '0;
   logic [2:0]    resp_valid;
   logic [31:0]   resp_data;
   logic          mem_req_valid;
   logic          mem_req_ready = 1'b0;
   logic          mem_req_op;
   logic [2:0]    mem_req_op_type;
   logic [31:0]   mem_req_addr;
   logic [31:0]   mem_req_data;
   logic          mem_resp_valid = 1'b0;
   logic [31:0]   mem_resp_data = '0;
   logic          err_orphan_resp;

   riscv_soft_mem_arbiter #(
      .N_CH(NC), .ADDR_W(32), .DATA_W(32), .OPT_W(3), .MAX_OUT(MO)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_op_type(req_op_type),
      .req_addr(req_addr), .req_data(req_data),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_op(mem_req_op), .mem_req_op_type(mem_req_op_type),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .err_orphan_resp(err_orphan_resp)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        f_op   [NC];
   logic [2:0]  f_ot   [NC];
   logic [31:0] f_addr [NC];
   logic [31:0] f_data [NC];

   int          q [$];
   int          rr = 0;
   logic [2:0]  e_rv = '0;
   logic [31:0] e_rd = '0;
   logic        e_err = 1'b0;
   int          grants [$];

   task automatic chk(input string tag, input logic [67:0] got,
                      input logic [67:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_fields(input logic [31:0] base);
      for (int i = 0; i < NC; i++) begin
         f_op[i]   = i[0];
         f_ot[i]   = 3'(i + 1);
         f_addr[i] = base + 32'(i * 'h100);
         f_data[i] = 32'hA000_0000 + base + 32'(i);
      end
   endtask

   task automatic rand_fields();
      for (int i = 0; i < NC; i++) begin
         f_op[i]   = 1'($urandom);
         f_ot[i]   = 3'($urandom);
         f_addr[i] = $urandom;
         f_data[i] = $urandom;
      end
   endtask

   task automatic cyc(input logic [2:0] v, input logic rdy, input logic rv,
                      input logic [31:0] rd, input logic rst);
      int g;
      logic mv, fire, pop, orph;
      logic [2:0] erdy;
      logic [67:0] ebus;
      @(negedge clk);
      reset          = rst;
      req_valid      = v;
      mem_req_ready  = rdy;
      mem_resp_valid = rv;
      mem_resp_data  = rd;
      req_op      = {f_op[2], f_op[1], f_op[0]};
      req_op_type = {f_ot[2], f_ot[1], f_ot[0]};
      req_addr    = {f_addr[2], f_addr[1], f_addr[0]};
      req_data    = {f_data[2], f_data[1], f_data[0]};
      #1;
      g = -1;
      for (int k = 0; k < NC; k++)
         if (g < 0 && v[(rr + k) % NC]) g = (rr + k) % NC;
      pop  = rv && (q.size() > 0);
      orph = rv && (q.size() == 0);
      mv   = (g >= 0) && ((q.size() < MO) || pop);
      fire = mv && rdy;
      erdy = fire ? 3'(1 << g) : 3'b000;
      ebus = (g >= 0) ? {f_op[g], f_ot[g], f_addr[g], f_data[g]} : '0;
      chk("mem_req_valid", 68'(mem_req_valid), 68'(mv));
      chk("req_ready", 68'(req_ready), 68'(erdy));
      chk("mem_req_fields",
          {mem_req_op, mem_req_op_type, mem_req_addr, mem_req_data}, ebus);
      @(posedge clk);
      if (rst) begin
         q.delete();
         rr = 0; e_rv = '0; e_rd = '0; e_err = 1'b0;
      end else begin
         if (pop) begin
            e_rv = 3'(1 << q.pop_front());
            e_rd = rd;
         end else begin
            e_rv = '0;
         end
         if (fire) begin
            q.push_back(g);
            grants.push_back(g);
            rr = (g + 1) % NC;
         end
         if (orph) e_err = 1'b1;
      end
      #1;
      chk("resp_valid", 68'(resp_valid), 68'(e_rv));
      chk("resp_data", 68'(resp_data), 68'(e_rd));
      chk("err_orphan_resp", 68'(err_orphan_resp), 68'(e_err));
   endtask

   task automatic drain();
      for (int n = 0; n < 8 && q.size() > 0; n++)
         cyc(3'b000, 1'b1, 1'b1, 32'h5A00_0000 + 32'(n), 1'b0);
      cyc(3'b000, 1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      set_fields(32'h0);
      cyc(3'b000, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(3'b000, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(3'b000, 1'b0, 1'b0, 32'h0, 1'b0);

      // single read on ch1, response two cycles later
      cyc(3'b010, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("ch1_addr_seen", 68'(grants[grants.size()-1]), 68'(1));
      cyc(3'b000, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(3'b000, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      chk("ch1_resp_valid", 68'(resp_valid), 68'(3'b010));
      chk("ch1_resp_data", 68'(resp_data), 68'(32'hDEAD_BEEF));

      // round robin with all channels held valid
      grants.delete();
      set_fields(32'h1000);
      for (int n = 0; n < 6; n++)
         cyc(3'b111, 1'b1, q.size() > 0, 32'h1111_0000 + 32'(n), 1'b0);
      for (int n = 0; n < 6; n++)
         chk("rr_order", 68'(grants[n]), 68'((n + 2) % NC));
      drain();

      // back-pressure on ch2, then a single fire
      grants.delete();
      set_fields(32'h2000);
      for (int n = 0; n < 5; n++)
         cyc(3'b100, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(3'b100, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("bp_single_fire", 68'(grants.size()), 68'(1));
      drain();

      // fill the tag FIFO, stall, then fire with a same-cycle pop
      grants.delete();
      set_fields(32'h3000);
      for (int n = 0; n < 4; n++)
         cyc(3'b111, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(3'b111, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("full_stall", 68'(grants.size()), 68'(4));
      cyc(3'b111, 1'b1, 1'b1, 32'h3333_0000, 1'b0);
      chk("full_fire", 68'(grants.size()), 68'(5));
      for (int n = 0; n < 4; n++)
         chk("full_order", 68'(grants[n]), 68'(n % NC));
      drain();

      // orphan response, sticky flag
      cyc(3'b000, 1'b1, 1'b1, 32'hBAD0_0001, 1'b0);
      cyc(3'b000, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(3'b000, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("orphan_sticky", 68'(err_orphan_resp), 68'(1));

      // two requests then reset clears everything
      cyc(3'b011, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(3'b011, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(3'b000, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(3'b000, 1'b1, 1'b1, 32'hBAD0_0002, 1'b0);
      cyc(3'b111, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("post_reset_rr", 68'(grants[grants.size()-1]), 68'(0));
      drain();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic rv;
         rand_fields();
         rv = (q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 49) == 0);
         cyc(3'($urandom), $urandom_range(0, 3) != 0, rv, $urandom, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
